// File: rtl/ise_sort_param.sv
// Image sorting engine: classifies streamed RGB pixels by dominant channel, averages the
// winning class with a restoring divider, insertion-sorts per-image results, then streams them out.
module ise_sort_param #(
  parameter int COLOR_W     = 8,
  parameter int PIX_PER_IMG = 16384,
  parameter int NUM_IMG     = 32,
  parameter int IDX_W       = 5,
  parameter int CNT_W       = $clog2(PIX_PER_IMG + 1),
  parameter int SUM_W       = COLOR_W + CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IDX_W-1:0]     image_in_index,
  input  logic [3*COLOR_W-1:0] pixel_in,
  input  logic                 batch_end,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           color_index,
  output logic [IDX_W-1:0]     image_out_index,
  output logic [COLOR_W-1:0]   avg_out
);

  localparam int TAB_W = $clog2(NUM_IMG + 1);
  localparam int PTR_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;
  localparam int BIT_W = (COLOR_W > 1) ? $clog2(COLOR_W) : 1;

  typedef enum logic [2:0] {ACCUM, SELECT, DIV, INSERT, OUTPUT} state_t;

  typedef struct packed {
    logic [1:0]         color;
    logic [COLOR_W-1:0] avg;
    logic [IDX_W-1:0]   idx;
  } entry_t;

  state_t             r_state;
  entry_t             r_tab [NUM_IMG];
  logic [TAB_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_cnt [3];
  logic [SUM_W-1:0]   r_sum [3];
  logic [CNT_W-1:0]   r_pixCnt;
  logic [IDX_W-1:0]   r_imgIdx;
  logic               r_batchEnd;
  logic               r_busy;
  logic               r_outValid;
  logic [1:0]         r_color;
  logic [SUM_W-1:0]   r_rem;
  logic [SUM_W-1:0]   r_den;
  logic [COLOR_W-1:0] r_quo;
  logic [BIT_W-1:0]   r_bit;

  logic [COLOR_W-1:0] w_r, w_g, w_b, w_clsVal;
  logic [1:0]         w_cls, w_dom;
  logic [CNT_W-1:0]   w_domCnt;
  logic [SUM_W-1:0]   w_domSum;
  logic [TAB_W-1:0]   w_insPos;
  entry_t             w_new;
  logic               w_accept, w_lastPix, w_lastOut;

  assign w_r       = pixel_in[3*COLOR_W-1 -: COLOR_W];
  assign w_g       = pixel_in[2*COLOR_W-1 -: COLOR_W];
  assign w_b       = pixel_in[COLOR_W-1:0];
  assign w_accept  = in_valid && !r_busy && (r_state == ACCUM);
  assign w_lastPix = (r_pixCnt == CNT_W'(PIX_PER_IMG - 1));
  assign w_lastOut = ((TAB_W'(r_rdPtr) + TAB_W'(1)) == r_count);
  assign w_new     = '{color: r_color, avg: r_quo, idx: r_imgIdx};

  always_comb begin
    w_cls    = 2'd2;
    w_clsVal = w_b;
    if (w_r >= w_g && w_r >= w_b) begin
      w_cls    = 2'd0;
      w_clsVal = w_r;
    end else if (w_g >= w_b) begin
      w_cls    = 2'd1;
      w_clsVal = w_g;
    end
  end

  // Ties between class counts resolve toward R, then G.
  always_comb begin
    w_dom    = 2'd2;
    w_domCnt = r_cnt[2];
    w_domSum = r_sum[2];
    if (r_cnt[0] >= r_cnt[1] && r_cnt[0] >= r_cnt[2]) begin
      w_dom    = 2'd0;
      w_domCnt = r_cnt[0];
      w_domSum = r_sum[0];
    end else if (r_cnt[1] >= r_cnt[2]) begin
      w_dom    = 2'd1;
      w_domCnt = r_cnt[1];
      w_domSum = r_sum[1];
    end
  end

  // Counting entries with key <= new key places equal keys after older ones (stable).
  always_comb begin
    w_insPos = '0;
    for (int i = 0; i < NUM_IMG; i++) begin
      if (TAB_W'(i) < r_count && {r_tab[i].color, r_tab[i].avg} <= {w_new.color, w_new.avg})
        w_insPos = w_insPos + TAB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ACCUM;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_pixCnt   <= '0;
      r_imgIdx   <= '0;
      r_batchEnd <= 1'b0;
      r_busy     <= 1'b0;
      r_outValid <= 1'b0;
      r_color    <= '0;
      r_rem      <= '0;
      r_den      <= '0;
      r_quo      <= '0;
      r_bit      <= '0;
      for (int c = 0; c < 3; c++) begin
        r_cnt[c] <= '0;
        r_sum[c] <= '0;
      end
      for (int i = 0; i < NUM_IMG; i++) r_tab[i] <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            for (int c = 0; c < 3; c++) begin
              if (w_cls == 2'(c)) begin
                r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                r_sum[c] <= r_sum[c] + SUM_W'(w_clsVal);
              end
            end
            if (r_pixCnt == '0) r_imgIdx <= image_in_index;
            if (batch_end) r_batchEnd <= 1'b1;
            r_pixCnt <= r_pixCnt + CNT_W'(1);
            if (w_lastPix) begin
              r_state <= SELECT;
              r_busy  <= 1'b1;
            end
          end
        end
        SELECT: begin
          r_color <= w_dom;
          r_rem   <= w_domSum;
          r_den   <= SUM_W'(w_domCnt) << (COLOR_W - 1);
          r_bit   <= BIT_W'(COLOR_W - 1);
          r_state <= DIV;
        end
        DIV: begin
          if (r_rem >= r_den) begin
            r_rem <= r_rem - r_den;
            r_quo <= {r_quo[COLOR_W-2:0], 1'b1};
          end else begin
            r_quo <= {r_quo[COLOR_W-2:0], 1'b0};
          end
          r_den <= r_den >> 1;
          r_bit <= r_bit - BIT_W'(1);
          if (r_bit == '0) r_state <= INSERT;
        end
        INSERT: begin
          if (w_insPos == '0) r_tab[0] <= w_new;
          for (int j = 1; j < NUM_IMG; j++) begin
            if (TAB_W'(j) == w_insPos)     r_tab[j] <= w_new;
            else if (TAB_W'(j) > w_insPos) r_tab[j] <= r_tab[j-1];
          end
          r_count  <= r_count + TAB_W'(1);
          r_pixCnt <= '0;
          for (int c = 0; c < 3; c++) begin
            r_cnt[c] <= '0;
            r_sum[c] <= '0;
          end
          if (r_batchEnd || r_count == TAB_W'(NUM_IMG - 1)) begin
            r_state    <= OUTPUT;
            r_outValid <= 1'b1;
            r_batchEnd <= 1'b0;
            r_rdPtr    <= '0;
          end else begin
            r_state <= ACCUM;
            r_busy  <= 1'b0;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (w_lastOut) begin
              r_outValid <= 1'b0;
              r_count    <= '0;
              r_rdPtr    <= '0;
              r_state    <= ACCUM;
              r_busy     <= 1'b0;
            end else begin
              r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign busy            = r_busy;
  assign out_valid       = r_outValid;
  assign color_index     = r_tab[r_rdPtr].color;
  assign avg_out         = r_tab[r_rdPtr].avg;
  assign image_out_index = r_tab[r_rdPtr].idx;

endmodule

// File: tb/tb_ise_sort_param.sv
// Bench for ise_sort_param: directed scenarios plus random batches checked against a
// per-image reference built from the classification/averaging/stable-sort rules.
module tb_ise_sort_param;

  localparam int COLOR_W = 8;
  localparam int PIX     = 4;
  localparam int NIMG    = 4;
  localparam int IDX_W   = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic [IDX_W-1:0]   image_in_index = '0;
  logic [3*COLOR_W-1:0] pixel_in = '0;
  logic               batch_end = 1'b0;
  logic               busy;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [1:0]         color_index;
  logic [IDX_W-1:0]   image_out_index;
  logic [COLOR_W-1:0] avg_out;

  ise_sort_param #(
    .COLOR_W(COLOR_W), .PIX_PER_IMG(PIX), .NUM_IMG(NIMG), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .image_in_index(image_in_index),
    .pixel_in(pixel_in), .batch_end(batch_end), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .color_index(color_index), .image_out_index(image_out_index),
    .avg_out(avg_out)
  );

  always #5 clk = ~clk;

  typedef struct {int color; int avg; int idx;} entry_t;

  int          vectors = 0;
  int          miscompares = 0;
  entry_t      model[$];
  entry_t      expQ[$];
  bit          tbPending = 1'b0;
  logic [23:0] imgPix [PIX];

  function automatic entry_t mk(input int c, input int a, input int i);
    entry_t e;
    e.color = c; e.avg = a; e.idx = i;
    return e;
  endfunction

  function automatic entry_t refEntry(input int idx);
    int cnt[3];
    int sum[3];
    int r, g, b, dom;
    for (int c = 0; c < 3; c++) begin cnt[c] = 0; sum[c] = 0; end
    for (int p = 0; p < PIX; p++) begin
      r = int'(imgPix[p][23:16]); g = int'(imgPix[p][15:8]); b = int'(imgPix[p][7:0]);
      if (r >= g && r >= b) begin cnt[0]++; sum[0] += r; end
      else if (g >= b)      begin cnt[1]++; sum[1] += g; end
      else                  begin cnt[2]++; sum[2] += b; end
    end
    dom = 0;
    if (cnt[1] > cnt[dom]) dom = 1;
    if (cnt[2] > cnt[dom]) dom = 2;
    return mk(dom, sum[dom] / cnt[dom], idx);
  endfunction

  // Repeated minimum selection; strict '<' keeps the earliest arrival among equal keys.
  function automatic void buildExpected();
    entry_t tmp[$];
    int best;
    tmp = model;
    expQ.delete();
    while (tmp.size() > 0) begin
      best = 0;
      for (int j = 1; j < tmp.size(); j++)
        if (tmp[j].color * 256 + tmp[j].avg < tmp[best].color * 256 + tmp[best].avg) best = j;
      expQ.push_back(tmp[best]);
      tmp.delete(best);
    end
  endfunction

  function automatic logic [7:0] pickChan();
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic sendImage(input int idx, input int bePos, input bit skipWindow);
    int w;
    for (int p = 0; p < PIX; p++) begin
      w = 0;
      while (busy !== 1'b0 && w < 200) begin @(negedge clk); w++; end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL accept_wait busy=%b required 0", busy);
      end
      in_valid       = 1'b1;
      pixel_in       = imgPix[p];
      image_in_index = (p == 0) ? IDX_W'(idx) : IDX_W'($urandom);
      batch_end      = (p == bePos);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    batch_end = 1'b0;
    model.push_back(refEntry(idx));
    if (bePos >= 0) tbPending = 1'b1;
    if (!skipWindow && !(tbPending || model.size() == NIMG)) begin
      for (int k = 0; k < COLOR_W + 2; k++) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL busy_window cycle %0d busy=%b required 1", k, busy);
        end
        in_valid  = 1'b1;
        pixel_in  = 24'($urandom);
        batch_end = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      in_valid  = 1'b0;
      batch_end = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL busy_release busy=%b required 0", busy);
      end
    end
  endtask

  task automatic drainOutputs(input int holdCycles, input bit useModel);
    int w, i, guard, hold;
    bit rdy;
    if (useModel) buildExpected();
    w = 0;
    while (out_valid !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    vectors++;
    if (w != COLOR_W + 2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL output_latency cycles=%0d out_valid=%b required %0d/1", w, out_valid, COLOR_W + 2);
    end
    i = 0; guard = 0; hold = holdCycles;
    while (i < expQ.size() && guard < 1000) begin
      vectors++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL out_valid_busy entry %0d got %b/%b required 1/1", i, out_valid, busy);
      end
      vectors++;
      if ({color_index, avg_out, image_out_index} !==
          {2'(expQ[i].color), 8'(expQ[i].avg), 5'(expQ[i].idx)}) begin
        miscompares++;
        $display("[TB] FAIL entry %0d got (%0d,%0d,%0d) required (%0d,%0d,%0d)", i,
                 color_index, avg_out, image_out_index, expQ[i].color, expQ[i].avg, expQ[i].idx);
      end
      if (hold > 0) begin rdy = 1'b0; hold--; end
      else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      @(negedge clk);
      if (rdy) i++;
      guard++;
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || i != expQ.size()) begin
      miscompares++;
      $display("[TB] FAIL drain_end out_valid=%b busy=%b taken=%0d required 0/0/%0d",
               out_valid, busy, i, expQ.size());
    end
    model.delete();
    tbPending = 1'b0;
  endtask

  task automatic fillImage(input logic [23:0] px);
    for (int p = 0; p < PIX; p++) imgPix[p] = px;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, out_valid, color_index, image_out_index, avg_out} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got %b/%b/%0d/%0d/%0d required all 0",
               busy, out_valid, color_index, image_out_index, avg_out);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    fillImage(24'hFF0000);
    sendImage(5, PIX - 1, 1'b0);
    expQ.delete();
    expQ.push_back(mk(0, 255, 5));
    drainOutputs(0, 1'b0);
  endtask

  task automatic test_ties();
    imgPix[0] = 24'h808080; imgPix[1] = 24'h200000;
    imgPix[2] = 24'h00F000; imgPix[3] = 24'h00F000;
    sendImage(1, PIX - 1, 1'b0);
    expQ.delete();
    expQ.push_back(mk(0, 80, 1));
    drainOutputs(0, 1'b0);
  endtask

  task automatic test_sort_backpressure();
    fillImage(24'h000064); sendImage(7, -1, 1'b0);
    fillImage(24'h320000); sendImage(3, -1, 1'b0);
    fillImage(24'h140000); sendImage(9, PIX - 1, 1'b0);
    expQ.delete();
    expQ.push_back(mk(0, 20, 9));
    expQ.push_back(mk(0, 50, 3));
    expQ.push_back(mk(2, 100, 7));
    drainOutputs(3, 1'b0);
  endtask

  task automatic test_full_table();
    fillImage(24'h000000); sendImage(10, -1, 1'b0);
    fillImage(24'h0A0B0C); sendImage(11, -1, 1'b0);
    fillImage(24'h0A0000); sendImage(12, -1, 1'b0);
    fillImage(24'h000A00); sendImage(13, -1, 1'b0);
    expQ.delete();
    expQ.push_back(mk(0, 0, 10));
    expQ.push_back(mk(0, 10, 12));
    expQ.push_back(mk(1, 10, 13));
    expQ.push_back(mk(2, 12, 11));
    drainOutputs(1, 1'b0);
  endtask

  task automatic test_reset_mid_div();
    fillImage(24'h0000F0); sendImage(2, -1, 1'b0);
    fillImage(24'hF00000); sendImage(4, -1, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if ({busy, out_valid, color_index, image_out_index, avg_out} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_div got %b/%b/%0d/%0d/%0d required all 0",
               busy, out_valid, color_index, image_out_index, avg_out);
    end
    model.delete();
    tbPending = 1'b0;
    fillImage(24'h00F000); sendImage(6, PIX - 1, 1'b0);
    expQ.delete();
    expQ.push_back(mk(1, 240, 6));
    drainOutputs(0, 1'b0);
  endtask

  task automatic test_random_batches();
    int n, bePos;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, NIMG);
      for (int im = 0; im < n; im++) begin
        for (int p = 0; p < PIX; p++) imgPix[p] = {pickChan(), pickChan(), pickChan()};
        bePos = -1;
        if (im == n - 1 && (n < NIMG || $urandom_range(0, 1) == 1)) bePos = $urandom_range(0, PIX - 1);
        sendImage(int'($urandom_range(0, 31)), bePos, 1'b0);
      end
      drainOutputs($urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ties();
    test_sort_backpressure();
    test_full_table();
    test_reset_mid_div();
    test_random_batches();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ise_sort_param.md
Name: ise_sort_param

Overview:
- Parametrised successor to the image sorting engine.
- Accepts a stream of RGB pixels grouped into images and classifies each pixel by its dominant channel.
- Per image, picks the dominant colour and computes the average intensity of that colour's pixels with a sequential divider, then insertion-sorts the image into a table.
- At batch end, streams the sorted table out under a valid/ready handshake.
- Generalises pixel width, image size and table depth; adds an explicit batch end, input valid and output backpressure.

Parameters:
- COLOR_W, 8, bits per colour channel
- PIX_PER_IMG, 16384, pixels per image (power of 2 not required, must be >=1)
- NUM_IMG, 32, sort table depth (max images per batch)
- IDX_W, 5, image index width
- CNT_W, $clog2(PIX_PER_IMG+1), per-class pixel counter width
- SUM_W, COLOR_W+CNT_W, per-class intensity accumulator width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous active-low reset
- in_valid  in  1  pixel_in/image_in_index valid this cycle
- image_in_index  in  IDX_W  index of the image being streamed; sampled with the first accepted pixel of each image
- pixel_in  in  3*COLOR_W  {R,G,B}, R in MSBs
- batch_end  in  1  last image of batch; sampled on any accepted pixel of that image
- busy  out  1  high = pixels not accepted
- out_valid  out  1  sorted entry present
- out_ready  in  1  consumer accepts entry
- color_index  out  2  0=R, 1=G, 2=B
- image_out_index  out  IDX_W  sorted image index
- avg_out  out  COLOR_W  average intensity of dominant colour

Behaviour:
- Reset (reset==0 at clk edge): busy=0, out_valid=0, color_index=0, image_out_index=0, avg_out=0; table emptied; counters, accumulators and pending batch_end flag cleared. Reset wins over every other event in any state.
- Accept: a pixel is consumed when in_valid && !busy. Pixels presented while busy are dropped (no effect).
- Classify each pixel:
  - R if R>=G && R>=B;
  - else G if G>=B;
  - else B.
  - Add 1 to that class count; add that class's channel value to that class sum.
- States: ACCUM, SELECT, DIV, INSERT, OUTPUT.
- ACCUM:
  - Pixel counter increments per accepted pixel.
  - On acceptance of pixel PIX_PER_IMG-1 -> SELECT next cycle.
  - busy=0.
- SELECT (1 cycle):
  - Dominant colour = class with max count; ties resolved R>G>B.
  - Load divider with that class's sum and count; count is nonzero by construction.
  - busy=1.
- DIV (exactly COLOR_W cycles):
  - Restoring division, one quotient bit per cycle, MSB first.
  - Result = floor(sum/count), COLOR_W bits; the quotient cannot exceed 2^COLOR_W-1.
- INSERT (1 cycle):
  - Insert {color, avg, index} into the table.
  - Ordering is ascending by color, then ascending by avg; equal keys keep arrival order (stable).
  - Entries at or after the insertion point shift down one slot in parallel.
  - Clear counts, sums and pixel counter.
  - Next state is OUTPUT if the pending batch_end flag is set or the table now holds NUM_IMG entries; otherwise ACCUM.
- Per-image busy window: busy rises the cycle after the last pixel and stays high COLOR_W+2 cycles. In ACCUM, busy falls the cycle after INSERT.
- OUTPUT:
  - busy=1; out_valid=1 with slot 0 on the first OUTPUT cycle.
  - The entry advances only on out_valid && out_ready.
  - While out_ready=0, outputs are held stable.
  - After the last valid entry is accepted: out_valid=0, table cleared, back to ACCUM with busy=0 the next cycle.
- Output data is don't-care when out_valid=0 but must not change while out_valid=1 and out_ready=0.
- Table full without batch_end: automatic OUTPUT of all NUM_IMG entries.
- batch_end handling:
  - Asserting it on any pixel of an image sets a sticky flag.
  - The flag takes effect only after that image's INSERT.
  - The flag is cleared on entering OUTPUT.
- image_in_index changes mid-image are ignored; the index latched at the image's first pixel is used.

Test Plan (PIX_PER_IMG=4, NUM_IMG=4, COLOR_W=8 unless noted):
1. Single image, index 5, four pixels 0xFF0000, batch_end on last -> after COLOR_W+2 busy cycles one entry: color_index=0, avg_out=255, image_out_index=5, then out_valid=0 and busy=0.
2. Tie rules, index 1: pixels 0x808080, 0x200000, 0x00F000, 0x00F000 -> counts R=2 (128+32), G=2 -> color R, avg 80.
3. Sort order: images idx 7 (all 0x000064, B avg 100), idx 3 (all 0x320000, R avg 50), idx 9 (all 0x140000, R avg 20), batch_end on idx 9 -> output order (0,20,9), (0,50,3), (2,100,7).
4. Backpressure: during OUTPUT hold out_ready=0 for 3 cycles -> out_valid stays 1 and outputs are unchanged; each following ready cycle advances exactly one entry.
5. Full table: 4 images, no batch_end -> OUTPUT entered automatically after the 4th INSERT. Pixels presented while busy are dropped; accumulator checks confirm this.
6. Reset mid-DIV on 2nd image -> next cycle busy=0, out_valid=0; a new single-image batch outputs only its own entry.
